fp_serial_input_deserializer: RTL and testbench

- Front-end stage of the FP adder top.
- Collects four LSB-first serial operand streams plus an 8-bit serial setup word during a 16-cycle write frame.
- Presents them as parallel registered words to the adder core through a valid/ready handshake.
- Drives the external input_rdy flag that tells the host when a new frame may start.

---
 rtl/fp_serial_input_deserializer.sv | 144 ++++++++++++++
 tb/tb_fp_serial_input_deserializer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_serial_input_deserializer.sv
// Gathers four LSB-first operand streams and a setup word over a WIDTH-cycle write frame.
// op_valid is high the cycle after the last bit edge; words are held until op_ready.
module fp_serial_input_deserializer #(
  parameter int WIDTH   = 16,
  parameter int SETUP_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               wr_in,
  input  logic               serial1_in,
  input  logic               serial2_in,
  input  logic               serial3_in,
  input  logic               serial4_in,
  input  logic               setup_serial_in,
  output logic               input_rdy,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic [WIDTH-1:0]   c_out,
  output logic [WIDTH-1:0]   d_out,
  output logic [SETUP_W-1:0] setup_out,
  output logic               frame_err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);
  localparam int SW = (SETUP_W > 1) ? $clog2(SETUP_W) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] SETUP_LIM = CW'(SETUP_W);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_armed;
  logic               r_valid;
  logic               r_err;
  logic [WIDTH-1:0]   r_sa, r_sb, r_sc, r_sd;
  logic [SETUP_W-1:0] r_ss;
  logic [WIDTH-1:0]   r_a, r_b, r_c, r_d;
  logic [SETUP_W-1:0] r_setup;

  logic [IW-1:0]      w_idx;
  logic [WIDTH-1:0]   w_a, w_b, w_c, w_d;
  logic [SETUP_W-1:0] w_s;

  // Next shift-register contents with the current bit dropped in at its own index,
  // so the final edge can load the outputs without waiting an extra cycle.
  always_comb begin
    w_idx      = r_cnt[IW-1:0];
    w_a        = r_sa;
    w_b        = r_sb;
    w_c        = r_sc;
    w_d        = r_sd;
    w_s        = r_ss;
    w_a[w_idx] = serial4_in;
    w_b[w_idx] = serial3_in;
    w_c[w_idx] = serial2_in;
    w_d[w_idx] = serial1_in;
    if (r_cnt < SETUP_LIM) w_s[r_cnt[SW-1:0]] = setup_serial_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_armed <= 1'b1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sc    <= '0;
      r_sd    <= '0;
      r_ss    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_setup <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!wr_in) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_sa    <= w_a;
            r_sb    <= w_b;
            r_sc    <= w_c;
            r_sd    <= w_d;
            r_ss    <= w_s;
            r_cnt   <= CW'(1);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!wr_in) begin
            // Strobe dropped early: the partial frame is abandoned, outputs untouched.
            r_err   <= 1'b1;
            r_armed <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_sa  <= w_a;
            r_sb  <= w_b;
            r_sc  <= w_c;
            r_sd  <= w_d;
            r_ss  <= w_s;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_BIT) begin
              r_a     <= w_a;
              r_b     <= w_b;
              r_c     <= w_c;
              r_d     <= w_d;
              r_setup <= w_s;
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (op_ready) begin
            r_valid <= 1'b0;
            r_armed <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign input_rdy = (r_state == IDLE) && r_armed;
  assign op_valid  = r_valid;
  assign frame_err = r_err;
  assign a_out     = r_a;
  assign b_out     = r_b;
  assign c_out     = r_c;
  assign d_out     = r_d;
  assign setup_out = r_setup;

endmodule

// File: tb/tb_fp_serial_input_deserializer.sv
// Directed bench for the serial input deserializer: frames, backpressure, abort, held strobe, reset.
module tb_fp_serial_input_deserializer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        wr_in;
  logic        serial1_in, serial2_in, serial3_in, serial4_in;
  logic        setup_serial_in;
  logic        input_rdy;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] a_out, b_out, c_out, d_out;
  logic [7:0]  setup_out;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  fp_serial_input_deserializer #(.WIDTH(16), .SETUP_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_in(wr_in),
    .serial1_in(serial1_in), .serial2_in(serial2_in),
    .serial3_in(serial3_in), .serial4_in(serial4_in),
    .setup_serial_in(setup_serial_in),
    .input_rdy(input_rdy), .op_valid(op_valid), .op_ready(op_ready),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .setup_out(setup_out), .frame_err(frame_err)
  );

  // Drives n frame bits, one per negedge; s carries the setup line for all 16 cycles.
  task automatic send_bits(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [15:0] d, input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] bi;
      bi = 4'(i);
      @(negedge clk_in);
      wr_in           = 1'b1;
      serial4_in      = a[bi];
      serial3_in      = b[bi];
      serial2_in      = c[bi];
      serial1_in      = d[bi];
      setup_serial_in = s[bi];
    end
  endtask

  task automatic accept();
    @(negedge clk_in);
    op_ready = 1'b1;
    @(negedge clk_in);
    op_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({a_out, b_out, c_out, d_out, setup_out} !== 72'h0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", {a_out, b_out, c_out, d_out, setup_out});
    end
    n_checks++;
    if ({op_valid, frame_err, input_rdy} !== 3'b001) begin
      n_fail++; $display("FAIL reset_flags: got valid/err/rdy=%b required 001", {op_valid, frame_err, input_rdy});
    end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] a, b, s;
    a = 16'h3C00; b = 16'h3C00; s = 16'h001E;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] bi;
      bi = 4'(i);
      @(negedge clk_in);
      if (i == 0) begin
        n_checks++;
        if (input_rdy !== 1'b1) begin
          n_fail++; $display("FAIL basic_rdy_before: got %b required 1", input_rdy);
        end
      end else begin
        n_checks++;
        if ({input_rdy, op_valid} !== 2'b00) begin
          n_fail++; $display("FAIL basic_in_frame bit %0d: got rdy/valid=%b required 00", i, {input_rdy, op_valid});
        end
      end
      wr_in = 1'b1;
      serial4_in = a[bi]; serial3_in = b[bi]; serial2_in = 1'b0; serial1_in = 1'b0;
      setup_serial_in = s[bi];
    end
    @(negedge clk_in);
    wr_in = 1'b0;
    n_checks++;
    if ({op_valid, input_rdy} !== 2'b10) begin
      n_fail++; $display("FAIL basic_valid: got valid/rdy=%b required 10", {op_valid, input_rdy});
    end
    n_checks++;
    if ({a_out, b_out, c_out, d_out, setup_out} !== {16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 8'h1E}) begin
      n_fail++; $display("FAIL basic_data: got %h required 3c003c00000000001e", {a_out, b_out, c_out, d_out, setup_out});
    end
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({op_valid, input_rdy} !== 2'b10) begin
      n_fail++; $display("FAIL basic_hold: got valid/rdy=%b required 10", {op_valid, input_rdy});
    end
    accept();
    @(negedge clk_in);
  endtask

  task automatic test_backpressure();
    logic [71:0] exp;
    exp = {16'h4880, 16'h3C00, 16'h3800, 16'h3400, 8'h1E};
    send_bits(16'h4880, 16'h3C00, 16'h3800, 16'h3400, 16'h001E, 16);
    @(negedge clk_in);
    wr_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if ({op_valid, a_out, b_out, c_out, d_out, setup_out} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL bp_stable cycle %0d: got %b/%h required 1/%h", k, op_valid,
                            {a_out, b_out, c_out, d_out, setup_out}, exp);
      end
      @(negedge clk_in);
    end
    op_ready = 1'b1;
    @(negedge clk_in);
    op_ready = 1'b0;
    n_checks++;
    if ({op_valid, input_rdy} !== 2'b00) begin
      n_fail++; $display("FAIL bp_accept: got valid/rdy=%b required 00", {op_valid, input_rdy});
    end
    @(negedge clk_in);
    n_checks++;
    if (input_rdy !== 1'b1) begin
      n_fail++; $display("FAIL bp_rearm: got rdy=%b required 1", input_rdy);
    end
  endtask

  task automatic test_abort();
    logic [71:0] prev;
    prev = {16'h4880, 16'h3C00, 16'h3800, 16'h3400, 8'h1E};
    send_bits(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5);
    @(negedge clk_in);
    wr_in = 1'b0;
    @(negedge clk_in);
    n_checks++;
    if ({frame_err, op_valid} !== 2'b10) begin
      n_fail++; $display("FAIL abort_err: got err/valid=%b required 10", {frame_err, op_valid});
    end
    n_checks++;
    if ({a_out, b_out, c_out, d_out, setup_out} !== prev) begin
      n_fail++; $display("FAIL abort_keep: got %h required %h", {a_out, b_out, c_out, d_out, setup_out}, prev);
    end
    @(negedge clk_in);
    n_checks++;
    if ({frame_err, op_valid, input_rdy} !== 3'b001) begin
      n_fail++; $display("FAIL abort_after: got err/valid/rdy=%b required 001", {frame_err, op_valid, input_rdy});
    end
    send_bits(16'h4200, 16'hC200, 16'h1234, 16'h5678, 16'h00A5, 16);
    @(negedge clk_in);
    wr_in = 1'b0;
    n_checks++;
    if ({op_valid, a_out, b_out, c_out, d_out, setup_out} !== {1'b1, 16'h4200, 16'hC200, 16'h1234, 16'h5678, 8'hA5}) begin
      n_fail++; $display("FAIL abort_next: got %b/%h required 1/4200c20012345678a5", op_valid,
                          {a_out, b_out, c_out, d_out, setup_out});
    end
    accept();
  endtask

  task automatic test_held_strobe();
    int nv, nr;
    nv = 0; nr = 0;
    op_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic [3:0]  bi;
      a  = 16'h1111;
      bi = 4'(i);
      @(negedge clk_in);
      if (op_valid) nv++;
      if (i > 0 && input_rdy) nr++;
      wr_in = 1'b1;
      serial4_in = (i < 16) ? a[bi] : 1'b1;
      serial3_in = 1'b0; serial2_in = 1'b0; serial1_in = 1'b0; setup_serial_in = 1'b0;
    end
    @(negedge clk_in);
    if (op_valid) nv++;
    wr_in = 1'b0;
    n_checks++;
    if (nv !== 1) begin
      n_fail++; $display("FAIL held_pulses: got %0d valid cycles required 1", nv);
    end
    n_checks++;
    if (nr !== 0) begin
      n_fail++; $display("FAIL held_rdy: got %0d ready cycles required 0", nr);
    end
    n_checks++;
    if (a_out !== 16'h1111) begin
      n_fail++; $display("FAIL held_a: got %h required 1111", a_out);
    end
    @(negedge clk_in);
    n_checks++;
    if (input_rdy !== 1'b1) begin
      n_fail++; $display("FAIL held_rearm: got rdy=%b required 1", input_rdy);
    end
    op_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    send_bits(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 9);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    n_checks++;
    if ({a_out, b_out, c_out, d_out, setup_out} !== 72'h0) begin
      n_fail++; $display("FAIL midrst_data: got %h required 0", {a_out, b_out, c_out, d_out, setup_out});
    end
    n_checks++;
    if ({op_valid, frame_err, input_rdy} !== 3'b001) begin
      n_fail++; $display("FAIL midrst_flags: got valid/err/rdy=%b required 001", {op_valid, frame_err, input_rdy});
    end
    wr_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if (op_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_novalid: got %b required 0", op_valid);
    end
    send_bits(16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'h001C, 16);
    @(negedge clk_in);
    wr_in = 1'b0;
    n_checks++;
    if ({op_valid, a_out, b_out, c_out, d_out, setup_out} !== {1'b1, 48'h0, 16'hABCD, 8'h1C}) begin
      n_fail++; $display("FAIL midrst_next: got %b/%h required 1/000000000000abcd1c", op_valid,
                          {a_out, b_out, c_out, d_out, setup_out});
    end
    accept();
  endtask

  task automatic test_setup_trunc();
    send_bits(16'h0F0F, 16'hF0F0, 16'h8001, 16'h7FFE, 16'hFFFF, 16);
    @(negedge clk_in);
    wr_in = 1'b0;
    n_checks++;
    if (setup_out !== 8'hFF) begin
      n_fail++; $display("FAIL trunc_setup: got %h required ff", setup_out);
    end
    n_checks++;
    if ({op_valid, a_out, b_out, c_out, d_out} !== {1'b1, 16'h0F0F, 16'hF0F0, 16'h8001, 16'h7FFE}) begin
      n_fail++; $display("FAIL trunc_ops: got %b/%h required 1/0f0ff0f080017ffe", op_valid,
                          {a_out, b_out, c_out, d_out});
    end
    accept();
  endtask

  initial begin
    rst_in = 1'b0; wr_in = 1'b0; op_ready = 1'b0;
    serial1_in = 1'b0; serial2_in = 1'b0; serial3_in = 1'b0; serial4_in = 1'b0;
    setup_serial_in = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_held_strobe();
    test_reset_midframe();
    test_setup_trunc();
    repeat (2) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
